// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU
// between two requesters. Each operation is accepted in IDLE, executed for
// one cycle (EXEC) and its captured result is held in RESP until the owning
// requester consumes it.
module alu_arbiter #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   // requester 0
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [3:0]        req0_sel,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   // requester 1
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [3:0]        req1_sel,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   // shared ALU
   output logic [3:0]        alu_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   // responses
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [15:0]       done_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic [3:0]          sel_q, sel_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                rsp_err_q, rsp_err_d;
   logic [15:0]         done_cnt_q, done_cnt_d;

   logic                grant;
   logic                accept;
   logic                complete;
   logic                illegal_op;

   // Grant: single valid requester wins; on a tie the one not granted last.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Op codes outside the supported set are flagged but still executed.
   always_comb begin
      unique case (sel_q)
         4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: illegal_op = 1'b0;
         default:                            illegal_op = 1'b1;
      endcase
   end

   assign accept   = req0_ready | req1_ready;
   assign complete = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept)   state_d = EXEC;
         EXEC:               state_d = RESP;
         RESP: if (complete) state_d = IDLE;
         default:            state_d = IDLE;
      endcase
   end

   // FSM outputs; ready is gated by reset_n so it stays low during reset
   // even when requesters keep valid asserted.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req0_ready = reset_n & req0_valid & ~grant;
            req1_ready = reset_n & req1_valid &  grant;
         end
         RESP: begin
            rsp0_valid = ~owner_q;
            rsp1_valid =  owner_q;
         end
         default: ;
      endcase
   end

   // Datapath next-state: operand capture on accept, result capture in EXEC,
   // completion counting on the owner's handshake.
   always_comb begin
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      sel_d        = sel_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      done_cnt_d   = done_cnt_q;
      if (accept) begin
         owner_d      = grant;
         last_grant_d = grant;
         sel_d        = grant ? req1_sel : req0_sel;
         a_d          = grant ? req1_a   : req0_a;
         b_d          = grant ? req1_b   : req0_b;
      end
      if (state_q == EXEC) begin
         rsp_data_d = alu_result;
         rsp_zero_d = alu_zero;
         rsp_err_d  = illegal_op;
      end
      if (complete) begin
         done_cnt_d = done_cnt_q + 16'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         sel_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         done_cnt_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         sel_q        <= sel_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   assign alu_sel    = sel_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign done_count = done_cnt_q;

endmodule
